// File: rtl/yarp_branch_resolve.sv
// Purpose : yarp branch resolution unit: evaluates all six B-type conditions and
//           computes the target and fall-through PC. It also flags mispredicts and
//           illegal func3 values.
// Latency : LATENCY register stages (1 or 2) from acceptance to out_valid_o.
// Backpr. : valid/ready at both ends. A stage advances when it is empty or when its
//           downstream stage advances. in_ready_o depends combinationally on out_ready_i.
//
// Ports:
//   clk, reset_n        core clock, synchronous active-low reset
//   flush_i             drop every in-flight entry at the next edge (wins over advance)
//   in_valid_i/in_ready_o   request handshake
//     is_b_type_i, func3_i, opr_a_i, opr_b_i, pc_i, imm_i, pred_taken_i, tag_i
//   out_valid_o/out_ready_i result handshake
//     taken_o, target_o, redirect_pc_o, mispredict_o, illegal_o, tag_o
//   br_cnt_o, misp_cnt_o  performance counters. These are live only when the
//                         YARP_BR_PERF_CNT_EN macro is defined; otherwise they are tied to 0.
module yarp_branch_resolve #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             is_b_type_i,
  input  logic [2:0]       func3_i,
  input  logic [XLEN-1:0]  opr_a_i,
  input  logic [XLEN-1:0]  opr_b_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [31:0]      br_cnt_o,
  output logic [31:0]      misp_cnt_o
);

  typedef struct packed {
    logic             is_b;
    logic             taken;
    logic             mispredict;
    logic             illegal;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  redirect;
    logic [TAG_W-1:0] tag;
  } payload_t;

  // ---------------------------------------------------------------------------
  // Condition evaluation and address arithmetic (all on the request side)
  // ---------------------------------------------------------------------------
  logic            w_eq, w_lt, w_ltu;
  logic            w_cond, w_bad_f3;
  logic            w_taken;
  logic [XLEN-1:0] w_target, w_fall;
  payload_t        w_new_pl;

  assign w_eq  = (opr_a_i == opr_b_i);
  assign w_ltu = (opr_a_i <  opr_b_i);
  assign w_lt  = ($signed(opr_a_i) < $signed(opr_b_i));

  always_comb begin
    w_cond   = 1'b0;
    w_bad_f3 = 1'b0;
    case (func3_i)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_bad_f3 = 1'b1;   // 010 / 011 have no branch meaning
    endcase
  end

  // Sums wrap modulo 2^XLEN. Alignment is checked elsewhere.
  assign w_target = pc_i + imm_i;
  assign w_fall   = pc_i + XLEN'(4);
  assign w_taken  = is_b_type_i && w_cond;

  always_comb begin
    w_new_pl            = '0;
    w_new_pl.is_b       = is_b_type_i;
    w_new_pl.taken      = w_taken;
    // For a non-branch, taken is 0, so the prediction itself is the mispredict.
    w_new_pl.mispredict = w_taken ^ pred_taken_i;
    w_new_pl.illegal    = is_b_type_i && w_bad_f3;
    w_new_pl.target     = w_target;
    w_new_pl.redirect   = w_taken ? w_target : w_fall;
    w_new_pl.tag        = tag_i;
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  logic     r_s0_vld;
  payload_t r_s0_pl;
  logic     w_adv0;     // stage 0 may take a new entry this cycle
  logic     w_accept;
  logic     w_out_vld;
  payload_t w_out_pl;

  // Flush blocks acceptance so that a request in the flush cycle is dropped.
  assign in_ready_o = !flush_i && w_adv0;
  assign w_accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s0_vld <= 1'b0;
      r_s0_pl  <= '0;
    end else if (flush_i) begin
      r_s0_vld <= 1'b0;
    end else if (w_adv0) begin
      r_s0_vld <= w_accept;
      // Payload loads only on a real entry so that idle outputs stay quiet.
      if (w_accept) r_s0_pl <= w_new_pl;
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_adv0    = !r_s0_vld || out_ready_i;
      assign w_out_vld = r_s0_vld;
      assign w_out_pl  = r_s0_pl;
    end else if (LATENCY == 2) begin : g_lat2
      logic     r_s1_vld;
      payload_t r_s1_pl;
      logic     w_adv1;

      assign w_adv1 = !r_s1_vld || out_ready_i;
      assign w_adv0 = !r_s0_vld || w_adv1;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_s1_vld <= 1'b0;
          r_s1_pl  <= '0;
        end else if (flush_i) begin
          r_s1_vld <= 1'b0;
        end else if (w_adv1) begin
          r_s1_vld <= r_s0_vld;
          if (r_s0_vld) r_s1_pl <= r_s0_pl;
        end
      end

      assign w_out_vld = r_s1_vld;
      assign w_out_pl  = r_s1_pl;
    end else begin : g_bad_latency
      $error("yarp_branch_resolve: LATENCY must be 1 or 2");
      assign w_adv0    = 1'b0;
      assign w_out_vld = 1'b0;
      assign w_out_pl  = '0;
    end
  endgenerate

  assign out_valid_o   = w_out_vld;
  assign taken_o       = w_out_pl.taken;
  assign target_o      = w_out_pl.target;
  assign redirect_pc_o = w_out_pl.redirect;
  assign mispredict_o  = w_out_pl.mispredict;
  assign illegal_o     = w_out_pl.illegal;
  assign tag_o         = w_out_pl.tag;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef YARP_BR_PERF_CNT_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_misp_cnt;
  logic        w_done_br;

  // The result shown during a flush cycle is void, so it is never counted.
  assign w_done_br = w_out_vld && out_ready_i && !flush_i && w_out_pl.is_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_br_cnt   <= '0;
      r_misp_cnt <= '0;
    end else if (w_done_br) begin
      if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_out_pl.mispredict && (r_misp_cnt != 32'hFFFF_FFFF))
        r_misp_cnt <= r_misp_cnt + 32'd1;
    end
  end

  assign br_cnt_o   = r_br_cnt;
  assign misp_cnt_o = r_misp_cnt;
`else
  logic w_unused_is_b;
  assign w_unused_is_b = w_out_pl.is_b;
  assign br_cnt_o      = 32'd0;
  assign misp_cnt_o    = 32'd0;
`endif

endmodule

// File: tb/tb_yarp_branch_resolve.sv
module tb_yarp_branch_resolve;

  localparam int XLEN = 32;
  localparam int LAT  = 2;
  localparam int TW   = 4;

  logic            clk = 1'b0;
  logic            reset_n, flush, in_valid, in_ready, is_b, pred;
  logic [2:0]      func3;
  logic [XLEN-1:0] opr_a, opr_b, pc, imm;
  logic [TW-1:0]   tag;
  logic            out_valid, out_ready, taken, misp, ill;
  logic [XLEN-1:0] target, redirect;
  logic [TW-1:0]   tag_o;
  logic [31:0]     br_cnt, misp_cnt;

  yarp_branch_resolve #(.XLEN(XLEN), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .is_b_type_i(is_b), .func3_i(func3), .opr_a_i(opr_a), .opr_b_i(opr_b),
    .pc_i(pc), .imm_i(imm), .pred_taken_i(pred), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .taken_o(taken), .target_o(target), .redirect_pc_o(redirect),
    .mispredict_o(misp), .illegal_o(ill), .tag_o(tag_o),
    .br_cnt_o(br_cnt), .misp_cnt_o(misp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isb;
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm;
    logic        pred;
    logic [3:0]  tag;
    logic        e_taken;
    logic [31:0] e_tgt, e_red;
    logic        e_misp, e_ill;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Outputs captured by send() at the cycle the result is first valid.
  logic        c_taken, c_misp, c_ill;
  logic [31:0] c_tgt, c_red;
  logic [3:0]  c_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    is_b = v.isb; func3 = v.f3; opr_a = v.a; opr_b = v.b;
    pc = v.pc; imm = v.imm; pred = v.pred; tag = v.tag;
  endtask

  // One isolated request into an empty pipe. Checks the latency and captures the result.
  task automatic send(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 8);
    chk("latency", 64'(lat), 64'(LAT));
    c_taken = taken; c_misp = misp; c_ill = ill;
    c_tgt = target; c_red = redirect; c_tag = tag_o;
  endtask

  function automatic vec_t mk(input logic isb, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] p, input logic [31:0] i,
                              input logic pr, input logic [3:0] t,
                              input logic et, input logic [31:0] eg,
                              input logic [31:0] er, input logic em, input logic ei);
    vec_t v;
    v.isb = isb; v.f3 = f3; v.a = a; v.b = b; v.pc = p; v.imm = i;
    v.pred = pr; v.tag = t; v.e_taken = et; v.e_tgt = eg; v.e_red = er;
    v.e_misp = em; v.e_ill = ei;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   first_acc, first_out, last_out, nrx, sent, order_err, dropped, seen;
    logic [3:0] exp_tag;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_taken",     64'(taken),     64'd0);
    chk("rst_target",    64'(target),    64'd0);
    chk("rst_redirect",  64'(redirect),  64'd0);
    chk("rst_tag",       64'(tag_o),     64'd0);
    chk("rst_br_cnt",    64'(br_cnt),    64'd0);

    // ---------------- vector table ----------------
    //              isb f3     a             b             pc            imm           pr tag tk target        redirect      mp il
    vq.push_back(mk(1, 3'b000, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 1,  0, 32'h120,      32'h104,      0, 0));
    vq.push_back(mk(1, 3'b001, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 2,  1, 32'h120,      32'h120,      1, 0));
    vq.push_back(mk(1, 3'b100, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 3,  1, 32'h120,      32'h120,      1, 0));
    vq.push_back(mk(1, 3'b101, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 4,  0, 32'h120,      32'h104,      0, 0));
    vq.push_back(mk(1, 3'b110, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 5,  0, 32'h120,      32'h104,      0, 0));
    vq.push_back(mk(1, 3'b111, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 6,  1, 32'h120,      32'h120,      1, 0));
    vq.push_back(mk(1, 3'b010, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h20,       0, 7,  0, 32'h120,      32'h104,      0, 1));
    vq.push_back(mk(1, 3'b011, 32'h5,         32'h5,        32'h100,      32'h20,       1, 8,  0, 32'h120,      32'h104,      1, 1));
    vq.push_back(mk(1, 3'b100, 32'h8000_0000, 32'h1,        32'h200,      32'h40,       1, 9,  1, 32'h240,      32'h240,      0, 0));
    vq.push_back(mk(1, 3'b101, 32'h5,         32'h5,        32'h200,      32'h40,       0, 10, 1, 32'h240,      32'h240,      1, 0));
    vq.push_back(mk(1, 3'b110, 32'h5,         32'h5,        32'h200,      32'h40,       0, 11, 0, 32'h240,      32'h204,      0, 0));
    vq.push_back(mk(1, 3'b000, 32'h5,         32'h5,        32'hFFFF_FFFC, 32'h8,       1, 12, 1, 32'h4,        32'h4,        0, 0));
    vq.push_back(mk(1, 3'b001, 32'h5,         32'h5,        32'hFFFF_FFFC, 32'h8,       0, 13, 0, 32'h4,        32'h0,        0, 0));
    vq.push_back(mk(0, 3'b000, 32'h5,         32'h5,        32'h100,      32'h20,       1, 14, 0, 32'h120,      32'h104,      1, 0));
    vq.push_back(mk(0, 3'b010, 32'h5,         32'h6,        32'h100,      32'h20,       0, 15, 0, 32'h120,      32'h104,      0, 0));
    vq.push_back(mk(1, 3'b001, 32'h1,         32'h2,        32'h1000,     32'hFFFF_FFF0, 1, 0, 1, 32'hFF0,      32'hFF0,      0, 0));
    vq.push_back(mk(1, 3'b111, 32'h0,         32'hFFFF_FFFF, 32'h1000,    32'hFFFF_FFF0, 1, 3, 0, 32'hFF0,      32'h1004,     1, 0));

    foreach (vq[k]) begin
      send(vq[k]);
      chk($sformatf("v%0d_taken", k),    64'(c_taken), 64'(vq[k].e_taken));
      chk($sformatf("v%0d_target", k),   64'(c_tgt),   64'(vq[k].e_tgt));
      chk($sformatf("v%0d_redirect", k), 64'(c_red),   64'(vq[k].e_red));
      chk($sformatf("v%0d_misp", k),     64'(c_misp),  64'(vq[k].e_misp));
      chk($sformatf("v%0d_illegal", k),  64'(c_ill),   64'(vq[k].e_ill));
      chk($sformatf("v%0d_tag", k),      64'(c_tag),   64'(vq[k].tag));
    end

    // ---------------- streaming: tags 0..7 back to back ----------------
    v = vq[0];
    first_acc = -1; first_out = -1; last_out = -1; nrx = 0; sent = 0; order_err = 0;
    exp_tag = 4'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        if (tag_o !== exp_tag) order_err++;
        exp_tag++;
        nrx++;
      end
      if (sent < 8) begin
        v.tag = sent[3:0];
        drive(v);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("stream_first_latency", 64'(first_out - first_acc), 64'(LAT));
    chk("stream_span",          64'(last_out - first_out),  64'd7);
    chk("stream_count",         64'(nrx),                   64'd8);
    chk("stream_order_errs",    64'(order_err),             64'd0);

    // ---------------- backpressure: 3 requests, out_ready low 5 cycles ----------------
    nrx = 0; sent = 0; order_err = 0; dropped = 0; exp_tag = 4'd1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (out_valid && !out_ready && c >= 2) begin
        chk("bp_hold_tag",    64'(tag_o),  64'd1);
        chk("bp_hold_target", 64'(target), 64'h120);
      end
      if (out_valid && out_ready) begin
        if (tag_o !== exp_tag) order_err++;
        exp_tag++;
        nrx++;
      end
      if (sent < 3) begin
        v = vq[0];
        v.tag = 4'(sent + 1);
        v.pc  = 32'h100 * (sent + 1);
        drive(v);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && !in_ready) dropped = 1;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("bp_ready_dropped", 64'(dropped),   64'd1);
    chk("bp_count",         64'(nrx),       64'd3);
    chk("bp_order_errs",    64'(order_err), 64'd0);

    // ---------------- flush with 2 in flight + simultaneous input ----------------
    v = vq[1];
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      v.tag = 4'(9 + c);
      drive(v);
      in_valid = 1'b1;
    end
    @(negedge clk);
    v.tag = 4'd11;
    drive(v);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_results", 64'(seen), 64'd0);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    out_ready = 1'b0;
    v = vq[1]; v.tag = 4'd5; drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready",  64'(in_ready),  64'd1);
    chk("mrst_tag",       64'(tag_o),     64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_no_results", 64'(seen), 64'd0);

    // ---------------- counters: 10 branches, 3 mispredicts ----------------
    for (int i = 0; i < 10; i++) begin
      v = mk(1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, (i >= 3), 4'(i),
             1, 32'h120, 32'h120, (i < 3), 0);
      send(v);
      chk("cnt_seq_misp", 64'(c_misp), 64'(v.e_misp));
    end
    // Non-branch with prediction set: mispredict flag raised but not counted.
    send(mk(0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1, 4'd12, 0, 32'h120, 32'h104, 1, 0));
    chk("cnt_nonb_misp", 64'(c_misp), 64'd1);
    // Mispredicting branch flushed while being presented with out_ready high.
    @(negedge clk);
    drive(mk(1, 3'b001, 32'h5, 32'h5, 32'h100, 32'h20, 1, 4'd13, 0, 0, 0, 0, 0));
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cnt_flushed_presented", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (2) @(negedge clk);
`ifdef YARP_BR_PERF_CNT_EN
    chk("br_cnt",   64'(br_cnt),   64'd10);
    chk("misp_cnt", 64'(misp_cnt), 64'd3);
    @(negedge clk);
    force dut.r_br_cnt   = 32'hFFFF_FFFF;
    force dut.r_misp_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_br_cnt;
    release dut.r_misp_cnt;
    send(mk(1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 0, 4'd1, 1, 32'h120, 32'h120, 1, 0));
    repeat (2) @(negedge clk);
    chk("br_cnt_sat",   64'(br_cnt),   64'hFFFF_FFFF);
    chk("misp_cnt_sat", 64'(misp_cnt), 64'hFFFF_FFFF);
`else
    chk("br_cnt_tied",   64'(br_cnt),   64'd0);
    chk("misp_cnt_tied", 64'(misp_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/yarp_branch_resolve.md
Name: yarp_branch_resolve

Overview:
Pipelined, parametrised branch resolution unit for the yarp core. It takes one conditional branch per cycle over a valid/ready handshake and evaluates all six RV32/RV64 B-type conditions with true signed and unsigned compares. It also computes the branch target and fall-through PC, compares the outcome with the front-end prediction, and returns a registered redirect after a configurable latency. It sits between decode/operand read and the fetch redirect logic.

Parameters:
XLEN, 32, operand and PC width (32 or 64)
LATENCY, 1, pipeline depth from acceptance to result valid (1 or 2; any other value is an elaboration error)
TAG_W, 4, width of the instruction tag carried through unchanged

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset
flush_i  in  1  kill all in-flight entries
in_valid_i  in  1  request valid
in_ready_o  out  1  unit can accept a request
is_b_type_i  in  1  request is a conditional branch
func3_i  in  3  branch func3
opr_a_i  in  XLEN  rs1 value
opr_b_i  in  XLEN  rs2 value
pc_i  in  XLEN  branch PC
imm_i  in  XLEN  sign-extended B immediate
pred_taken_i  in  1  front-end prediction
tag_i  in  TAG_W  instruction tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
taken_o  out  1  resolved outcome
target_o  out  XLEN  pc_i + imm_i
redirect_pc_o  out  XLEN  taken ? target : pc_i + 4
mispredict_o  out  1  taken_o != pred_taken_i
illegal_o  out  1  is_b_type_i with func3 010 or 011
tag_o  out  TAG_W  tag of result
br_cnt_o  out  32  resolved-branch count (optional feature)
misp_cnt_o  out  32  mispredict count (optional feature)

Behaviour:
- Single clock, clk. reset_n is synchronous and active-low: sampled on the rising edge of clk, and reset applies while it is low.
- Reset: all stage valids 0, so out_valid_o = 0. Data outputs reset to 0. in_ready_o = 1 in the first cycle after reset releases.
- Conditions by func3: 000 BEQ (a==b); 001 BNE (a!=b); 100 BLT (signed a<b); 101 BGE (signed a>=b); 110 BLTU; 111 BGEU.
  - Signed compares use full two's-complement semantics, e.g. a = 0x8000_0000 < b = 0x0000_0001 is true.
  - func3 010/011: taken = 0, illegal_o = 1.
  - is_b_type_i = 0: taken = 0, illegal_o = 0, mispredict = pred_taken_i.
- Arithmetic: target and pc + 4 are computed modulo 2^XLEN (wrap, no overflow flag). No alignment check is done here.
- Pipeline: LATENCY register stages, each holding a valid bit plus the payload.
  - A request is accepted when in_valid_i && in_ready_o.
  - The result appears on out_valid_o exactly LATENCY cycles after acceptance if no stall occurs.
  - The result completes when out_valid_o && out_ready_i.
- Backpressure: a stage advances when it is empty or when its downstream stage advances. in_ready_o = !stage0_valid || stage0_advances. in_ready_o has a combinational path from out_ready_i.
  - Full-throughput sustained one request per cycle when out_ready_i = 1.
  - While out_ready_i = 0, out_valid_o holds and all outputs remain stable.
- Flush: flush_i = 1 clears every stage valid at the next edge.
  - in_ready_o is forced to 0 during the flush cycle, so a simultaneous input is dropped.
  - The output in the flush cycle is still presented, but the consumer must ignore it.
  - Flush has priority over advance.
- Reset mid-operation: all in-flight entries are discarded and no result is produced for them.

Optional Feature:
Macro YARP_BR_PERF_CNT_EN.
- Defined:
  - br_cnt_o increments on each completed result with is_b_type set.
  - misp_cnt_o increments on each completed result with is_b_type set and mispredict_o = 1.
  - Both counters saturate at 0xFFFF_FFFF, clear on reset, and are not affected by flush.
  - Flushed entries are never counted.
- Not defined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- All func3, XLEN=32: a = 0xFFFF_FFFF, b = 1 -> BLT 1, BGE 0, BLTU 0, BGEU 1, BEQ 0, BNE 1; func3 010 -> taken 0, illegal 1.
- Target wrap: pc = 0xFFFF_FFFC, imm = 8, BEQ a = b = 5 -> target_o = 0x0000_0004, redirect_pc_o = 0x0000_0004; with BNE -> redirect_pc_o = 0x0000_0000.
- LATENCY=2, continuous valid, out_ready = 1, tags 0..7 -> out_valid first seen 2 cycles after the first accept, one result per cycle, tags in order.
- Backpressure: hold out_ready = 0 for 5 cycles with 3 requests offered -> in_ready drops after the pipe fills, outputs stable, no loss or duplication after release.
- Flush with 2 entries in flight plus a simultaneous input -> out_valid = 0 the next cycle, and none of the 3 tags ever completes.
- YARP_BR_PERF_CNT_EN: 10 branches with 3 mispredicts plus 1 flushed -> br_cnt_o = 10, misp_cnt_o = 3; forced to 0xFFFF_FFFF -> stays saturated.
